// File: rtl/mmio_hub.sv
// Memory-mapped peripheral hub: LED/hex registers, switch input, keyboard FIFO,
// cascaded free-running timers and a sticky first-error capture register.
module mmio_hub #(
    parameter int US_DIV     = 50,
    parameter int NUM_TIMERS = 3,
    parameter int KBD_DEPTH  = 8,
    parameter int LED_W      = 16,
    parameter int SW_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    output logic             rvalid,
    input  logic [SW_W-1:0]  sw,
    input  logic [7:0]       kbd_code,
    input  logic             kbd_valid,
    output logic [LED_W-1:0] led,
    output logic [31:0]      hex,
    output logic             err
);
    function automatic logic [63:0] tmr_period(input int k);
        logic [63:0] p;
        p = 64'(US_DIV);
        for (int i = 0; i < k; i++) p = p * 64'd1000;
        return p;
    endfunction

    localparam logic [63:0] MAX_PERIOD = tmr_period(NUM_TIMERS - 1);
    localparam int PW = $clog2(MAX_PERIOD + 64'd1);
    localparam int AW = $clog2(KBD_DEPTH);
    localparam logic [1:0] E_RD = 2'd1, E_WR = 2'd2, E_BOTH = 2'd3;

    // Bus protocol: re/we are one-cycle strobes with no backpressure; every
    // read accepted alone (re without we) yields exactly one rvalid pulse,
    // with rdata, in the following cycle.
    logic [11:0] region;
    logic [1:0]  off;
    logic        rd_en, is_led, is_hex, is_sw, is_kdat, is_kstat, is_tmr, is_err;
    logic        tmr_off_ok, rd_mapped, wr_mapped, wr_ok;
    logic        unused_addr;

    assign region      = addr[31:20];
    assign off         = addr[3:2];
    assign unused_addr = ^{addr[19:4], addr[1:0]};
    assign rd_en       = re & ~we;
    assign is_led      = (region == 12'h001);
    assign is_hex      = (region == 12'h002);
    assign is_sw       = (region == 12'h003);
    assign is_kdat     = (region == 12'h004);
    assign is_kstat    = (region == 12'h005);
    assign is_tmr      = (region == 12'h006);
    assign is_err      = (region == 12'h007);
    assign tmr_off_ok  = (32'(off) < 32'(NUM_TIMERS));
    assign rd_mapped   = is_led | is_hex | is_sw | is_kdat | is_kstat |
                         (is_tmr & tmr_off_ok) | (is_err & ~off[1]);
    assign wr_mapped   = is_led | is_hex | (is_tmr & tmr_off_ok) | (is_err & ~off[1]);
    assign wr_ok       = we & wr_mapped;

    // Timer k prescales by US_DIV*1000^k; a bus write reloads value and phase.
    logic [31:0] tmr_val [4];
    for (genvar g = 0; g < 4; g++) begin : g_tmr
        if (g < NUM_TIMERS) begin : g_on
            localparam logic [PW-1:0] LAST = PW'(tmr_period(g) - 64'd1);
            logic [31:0]   tmr_q, tmr_d;
            logic [PW-1:0] pre_q, pre_d;
            logic          load;
            always_comb begin
                load  = wr_ok & is_tmr & (off == 2'(g));
                tmr_d = tmr_q;
                pre_d = pre_q + PW'(1);
                if (pre_q == LAST) begin
                    pre_d = '0;
                    tmr_d = tmr_q + 32'd1;
                end
                if (load) begin
                    tmr_d = wdata;
                    pre_d = '0;
                end
            end
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    tmr_q <= '0;
                    pre_q <= '0;
                end else begin
                    tmr_q <= tmr_d;
                    pre_q <= pre_d;
                end
            end
            assign tmr_val[g] = tmr_q;
        end else begin : g_off
            assign tmr_val[g] = '0;
        end
    end

    logic [7:0]  mem_q [KBD_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d, full, nonempty, push, pop, stat_rd;

    assign nonempty = (cnt_q != '0);
    assign full     = (cnt_q == (AW + 1)'(KBD_DEPTH));
    assign pop      = rd_en & is_kdat & nonempty;
    assign push     = kbd_valid & (~full | pop);
    assign stat_rd  = rd_en & is_kstat;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW + 1)'(1);
        // A drop in the same cycle as a status read must survive the clear.
        ovf_d = (kbd_valid & full & ~pop) | (ovf_q & ~stat_rd);
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= kbd_code;
    end

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      hex_q, hex_d, rdata_q, rdata_d, err_addr_q, err_addr_d, rd_mux;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       err_code_q, err_code_d, new_code;

    always_comb begin
        led_d = led_q;
        hex_d = hex_q;
        if (wr_ok && is_led) led_d = wdata[LED_W-1:0];
        if (wr_ok && is_hex) hex_d = wdata;

        rd_mux = '0;
        case (region)
            12'h001: rd_mux = 32'(led_q);
            12'h002: rd_mux = hex_q;
            12'h003: rd_mux = 32'(sw);
            12'h004: rd_mux = nonempty ? {24'b0, mem_q[rd_ptr_q]} : 32'd0;
            12'h005: rd_mux = {16'b0, 8'(cnt_q), 6'b0, ovf_q, nonempty};
            12'h006: rd_mux = tmr_val[off];
            12'h007: rd_mux = off[0] ? err_addr_q : 32'(err_code_q);
            default: rd_mux = '0;
        endcase
        rvalid_d = rd_en;
        rdata_d  = (rd_en && rd_mapped) ? rd_mux : 32'd0;

        new_code = 2'd0;
        if (re && we)              new_code = E_BOTH;
        else if (re && !rd_mapped) new_code = E_RD;
        else if (we && !wr_mapped) new_code = E_WR;

        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        if (wr_ok && is_err) begin
            err_code_d = '0;
            err_addr_d = '0;
        end
        if (new_code != 2'd0 && (err_code_q == 2'd0 || (wr_ok && is_err))) begin
            err_code_d = new_code;
            err_addr_d = addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q      <= '0;
            hex_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_code_q <= '0;
            err_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            hex_q      <= hex_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign led    = led_q;
    assign hex    = hex_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = (err_code_q != 2'd0);
endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: each task drives one feature and checks
// hand-computed expectations inline; inputs change and outputs are read on negedges.
module tb_mmio_hub;
    logic        clock, reset, we, re, kbd_valid, rvalid, err;
    logic [31:0] addr, wdata, rdata, hex;
    logic [15:0] sw, led;
    logic [7:0]  kbd_code;
    int n_cmp = 0;
    int n_fail = 0;

    mmio_hub dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .sw(sw), .kbd_code(kbd_code),
        .kbd_valid(kbd_valid), .led(led), .hex(hex), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called on a negedge; the access lands on the next posedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        addr = a; re = 1'b1;
        @(negedge clock);
        d = rdata; v = rvalid;
        re = 1'b0;
    endtask

    task automatic push_code(input logic [7:0] c);
        kbd_code = c; kbd_valid = 1'b1;
        @(negedge clock);
        kbd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3 reset = 1'b1;
        #2;
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (led !== 16'd0) begin n_fail++; $display("FAIL rst_led: got %h want 0", led); end
        n_cmp++; if (hex !== 32'd0) begin n_fail++; $display("FAIL rst_hex: got %h want 0", hex); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_led_hex_sw();
        logic [31:0] d; logic v;
        bus_write(32'h0010_0000, 32'h0000_A5A5);
        n_cmp++; if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_out: got %h want a5a5", led); end
        bus_read(32'h0010_0000, d, v);
        n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL led_rvalid: got %b want 1", v); end
        n_cmp++; if (d !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_rdata: got %h want 0000a5a5", d); end
        @(negedge clock);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b want 0", rvalid); end
        bus_write(32'h0010_0000, 32'hDEAD_1234);
        bus_read(32'h0010_0004, d, v);
        n_cmp++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL led_zext: got %h want 00001234", d); end
        bus_write(32'h0020_0000, 32'hCAFE_F00D);
        n_cmp++; if (hex !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hex_out: got %h want cafef00d", hex); end
        sw = 16'hBEEF;
        bus_read(32'h0020_0000, d, v);
        n_cmp++; if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hex_rdata: got %h want cafef00d", d); end
        bus_read(32'h0030_0000, d, v);
        n_cmp++; if (d !== 32'h0000_BEEF || v !== 1'b1) begin n_fail++; $display("FAIL sw_rdata: got %h/%b want 0000beef/1", d, v); end
    endtask

    task automatic test_kbd_overflow();
        logic [31:0] d; logic v;
        for (int i = 0; i < 9; i++) push_code(8'h10 + 8'(i));
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'h0000_0803) begin n_fail++; $display("FAIL kstat_full: got %h want 00000803", d); end
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h0040_0000, d, v);
            n_cmp++; if (d !== 32'h10 + 32'(i) || v !== 1'b1) begin n_fail++; $display("FAIL kdat_%0d: got %h/%b want %h/1", i, d, v, 32'h10 + 32'(i)); end
        end
        bus_read(32'h0040_0000, d, v);
        n_cmp++; if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL kdat_empty: got %h/%b want 0/1", d, v); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL kstat_drained: got %h want 0", d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL kdat_empty_noerr: got %b want 0", err); end
    endtask

    task automatic test_kbd_same_cycle();
        logic [31:0] d; logic v;
        for (int i = 0; i < 8; i++) push_code(8'h20 + 8'(i));
        addr = 32'h0050_0000; re = 1'b1; kbd_code = 8'h99; kbd_valid = 1'b1;
        @(negedge clock);
        d = rdata; re = 1'b0; kbd_valid = 1'b0;
        n_cmp++; if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL kstat_ovf_race_rd: got %h want 00000801", d); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'h0000_0803) begin n_fail++; $display("FAIL kstat_ovf_kept: got %h want 00000803", d); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL kstat_ovf_clr: got %h want 00000801", d); end
        addr = 32'h0040_0000; re = 1'b1; kbd_code = 8'h28; kbd_valid = 1'b1;
        @(negedge clock);
        d = rdata; re = 1'b0; kbd_valid = 1'b0;
        n_cmp++; if (d !== 32'h20) begin n_fail++; $display("FAIL full_pushpop_rd: got %h want 20", d); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL full_pushpop_stat: got %h want 00000801", d); end
        for (int i = 1; i < 9; i++) begin
            bus_read(32'h0040_0000, d, v);
            n_cmp++; if (d !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", i, d, 32'h20 + 32'(i)); end
        end
        addr = 32'h0040_0000; re = 1'b1; kbd_code = 8'h30; kbd_valid = 1'b1;
        @(negedge clock);
        d = rdata; v = rvalid; re = 1'b0; kbd_valid = 1'b0;
        n_cmp++; if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL empty_pushpop_rd: got %h/%b want 0/1", d, v); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL empty_pushpop_stat: got %h want 00000101", d); end
        bus_read(32'h0040_0000, d, v);
        n_cmp++; if (d !== 32'h30) begin n_fail++; $display("FAIL empty_pushpop_data: got %h want 30", d); end
    endtask

    task automatic test_timers();
        logic [31:0] d; logic v;
        bus_write(32'h0060_0000, 32'hFFFF_FFFF);
        repeat (49) @(negedge clock);
        bus_read(32'h0060_0000, d, v);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmr0_pre_wrap: got %h want ffffffff", d); end
        bus_read(32'h0060_0000, d, v);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL tmr0_wrap: got %h want 0", d); end
        bus_write(32'h0060_0004, 32'd7);
        repeat (49999) @(negedge clock);
        bus_read(32'h0060_0004, d, v);
        n_cmp++; if (d !== 32'd7) begin n_fail++; $display("FAIL tmr1_before: got %h want 7", d); end
        bus_read(32'h0060_0004, d, v);
        n_cmp++; if (d !== 32'd8) begin n_fail++; $display("FAIL tmr1_tick: got %h want 8", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic v;
        bus_read(32'h0FF0_0004, d, v);
        n_cmp++; if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL unmapped_rd: got %h/%b want 0/1", d, v); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        bus_write(32'h0030_0000, 32'h55);
        bus_read(32'h0070_0000, d, v);
        n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL err_code1: got %h want 1", d); end
        bus_read(32'h0070_0004, d, v);
        n_cmp++; if (d !== 32'h0FF0_0004) begin n_fail++; $display("FAIL err_addr1: got %h want 0ff00004", d); end
        bus_write(32'h0070_0000, 32'd0);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        bus_write(32'h0060_000C, 32'h1234);
        bus_read(32'h0070_0000, d, v);
        n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL err_code2: got %h want 2", d); end
        bus_read(32'h0070_0004, d, v);
        n_cmp++; if (d !== 32'h0060_000C) begin n_fail++; $display("FAIL err_addr2: got %h want 0060000c", d); end
        addr = 32'h0070_0000; wdata = 32'd0; re = 1'b1; we = 1'b1;
        @(negedge clock);
        v = rvalid; re = 1'b0; we = 1'b0;
        n_cmp++; if (v !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL clr_and_new: got rvalid %b err %b want 0/1", v, err); end
        bus_read(32'h0070_0000, d, v);
        n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL clr_and_new_code: got %h want 3", d); end
        bus_write(32'h0070_0000, 32'd0);
    endtask

    task automatic test_both_strobes();
        logic [31:0] d; logic v;
        addr = 32'h0010_0000; wdata = 32'h3; re = 1'b1; we = 1'b1;
        @(negedge clock);
        v = rvalid; re = 1'b0; we = 1'b0;
        n_cmp++; if (led !== 16'h0003) begin n_fail++; $display("FAIL both_led: got %h want 0003", led); end
        n_cmp++; if (v !== 1'b0) begin n_fail++; $display("FAIL both_rvalid: got %b want 0", v); end
        bus_read(32'h0070_0000, d, v);
        n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL both_code: got %h want 3", d); end
        bus_write(32'h0070_0000, 32'd0);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL both_clear: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d; logic v;
        for (int i = 0; i < 3; i++) push_code(8'h40 + 8'(i));
        bus_write(32'h0060_0000, 32'h100);
        bus_write(32'h0020_0000, 32'h1357_9BDF);
        bus_read(32'h0FF0_0000, d, v);
        addr = 32'h0030_0000; re = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_rvalid: got %b want 1", rvalid); end
        #1 reset = 1'b1; re = 1'b0;
        #1;
        n_cmp++; if (rdata !== 32'd0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd: got %h/%b want 0/0", rdata, rvalid); end
        n_cmp++; if (led !== 16'd0 || hex !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outs: got led %h hex %h err %b want 0", led, hex, err); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rvalid: got %b want 0", rvalid); end
        bus_read(32'h0050_0000, d, v);
        n_cmp++; if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL post_rst_kstat: got %h/%b want 0/1", d, v); end
        bus_read(32'h0060_0000, d, v);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL post_rst_tmr: got %h want 0", d); end
        bus_read(32'h0040_0000, d, v);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL post_rst_kdat: got %h want 0", d); end
    endtask

    initial begin
        reset = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        sw = '0; kbd_code = '0; kbd_valid = 1'b0;
        test_reset();
        test_led_hex_sw();
        test_kbd_overflow();
        test_kbd_same_cycle();
        test_timers();
        test_errors();
        test_both_strobes();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 Parameter US_DIV, default 50, clock cycles per microsecond tick (>=1).
REQ-002 Parameter NUM_TIMERS, default 3, free-running timers (1..4); timer k ticks every US_DIV*1000^k cycles (us, ms, s, ks).
REQ-003 Parameter KBD_DEPTH, default 8, keyboard FIFO entries (power of 2, >=2).
REQ-004 Parameter LED_W, default 16, LED register width; SW_W, default 16, switch input width.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 addr  in  32  byte address; region = addr[31:20], word offset = addr[3:2].
REQ-008 wdata  in  32  write data.
REQ-009 we  in  1  write strobe, one access per high cycle.
REQ-010 re  in  1  read strobe, one access per high cycle.
REQ-011 rdata  out  32  read data, valid when rvalid.
REQ-012 rvalid  out  1  one-cycle read-response pulse.
REQ-013 sw  in  SW_W  switch inputs.
REQ-014 kbd_code  in  8  scan code, qualified by kbd_valid.
REQ-015 kbd_valid  in  1  one-cycle push strobe per code.
REQ-016 led  out  LED_W  LED register.
REQ-017 hex  out  32  eight 4-bit digits for seven-segment display.
REQ-018 err  out  1  high while an error is latched.

Function
REQ-019 Region map SHALL be: 0x001 LED (RW), 0x002 HEX (RW), 0x003 SW (RO), 0x004 KBD_DATA (RO, pop), 0x005 KBD_STAT (RO), 0x006 TIMER (RW, offset selects timer), 0x007 ERR (offset 0 code, offset 1 captured addr; write clears); all other regions unmapped.
REQ-020 Read latency SHALL be exactly 1 cycle: re at edge N -> rvalid=1 and rdata during cycle N+1; rvalid=0 otherwise; back-to-back reads give back-to-back pulses.
REQ-021 Writes SHALL take effect at the edge where we=1; read-back in the next access sees new value.
REQ-022 LED write: led <= wdata[LED_W-1:0]; HEX write: hex <= wdata; reads zero-extend.
REQ-023 SW read returns zero-extended sw sampled at the re edge.
REQ-024 FIFO push on kbd_valid when not full; when full, code dropped and sticky overflow set.
REQ-025 KBD_DATA read when non-empty returns {24'b0, oldest code} and pops; when empty returns 0, no pop, no error.
REQ-026 Push and pop same cycle: both performed; when full, push succeeds (slot freed); when empty, read returns 0 and push succeeds (no bypass).
REQ-027 KBD_STAT read returns {count in bits [15:8], overflow bit 1, non-empty bit 0}, then clears overflow unless an overflow occurs in the same cycle.
REQ-028 Each timer: prescaler counts 0..period-1; at period-1 the timer increments, wrapping 0xFFFFFFFF -> 0.
REQ-029 TIMER write loads the selected timer with wdata and zeroes its prescaler; offset >= NUM_TIMERS is unmapped.
REQ-030 Error codes: 1 unmapped read, 2 unmapped or read-only write, 3 re and we both high.
REQ-031 re and we both high: write performed, read suppressed (no rvalid), code 3.
REQ-032 Unmapped read SHALL return rdata=0 with rvalid=1; invalid write changes no state.
REQ-033 First error latches code and addr; later errors ignored until ERR written (clear); clear and new error same cycle -> new error latched.
REQ-034 err = (latched code != 0).

Reset
REQ-035 Reset assertion SHALL immediately zero rdata, rvalid, led, hex, err, timers, prescalers, FIFO pointers/count, overflow, error code and address.
REQ-036 Reset mid-access SHALL abort it: no rvalid after reset deasserts for a read issued before it.
REQ-037 First access honoured at the first rising edge with reset low.

Verification
REQ-038 Write 0x0010_0000 <- 0x0000_A5A5, read back -> led=0xA5A5; rvalid one cycle after re, rdata=0x0000A5A5.
REQ-039 Push 9 codes 0x10..0x18 (KBD_DEPTH=8) -> KBD_STAT=0x0000_0803; 8 KBD_DATA reads return 0x10..0x17; 9th returns 0; next KBD_STAT=0x0000_0000.
REQ-040 Write timer 0 (0x0060_0000) <- 0xFFFF_FFFF, wait US_DIV cycles -> reads 0x0000_0000; timer 1 increments once per 50000 cycles.
REQ-041 Read 0x0FF0_0004 then write 0x0030_0000 -> rdata=0, err=1, ERR code reads 1, ERR addr reads 0x0FF00004; write ERR -> err=0.
REQ-042 re=we=1 on LED with 0x3 -> led=0x0003, no rvalid, code 3.
REQ-043 Assert reset during FIFO holding 3 codes and timer nonzero -> all outputs 0, KBD_STAT=0, timer reads 0 after release.
